// File: rtl/data_store.sv
// Write-back stage: takes R, G, B channel words in strict rotation, buffers them
// in a small FIFO and drains them to frame memory at a wrapping write address.
module data_store #(
    parameter int NUM_ADDRS = 115200,
    parameter int DEPTH     = 8
) (
    input  logic        clk,
    input  logic        rst_,
    input  logic        en,
    input  logic [31:0] r_data,
    input  logic        r_rts,
    output logic        r_rtr,
    input  logic [31:0] g_data,
    input  logic        g_rts,
    output logic        g_rtr,
    input  logic [31:0] b_data,
    input  logic        b_rts,
    output logic        b_rtr,
    output logic [31:0] out_data,
    output logic        out_rts,
    input  logic        out_rtr,
    output logic [16:0] mem_ptr,
    output logic        frame_done
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [16:0] LAST_ADDR = 17'(NUM_ADDRS - 1);
    localparam logic [2:0]  SEL_R = 3'b001;

    logic [2:0]    sel_q, sel_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic [CW-1:0] count_q, count_d;
    logic [16:0]   mem_ptr_q, mem_ptr_d;
    logic          frame_done_q, frame_done_d;
    logic [DEPTH-1:0][31:0] queue_q, queue_d;

    logic        full, empty, in_xfc, out_xfc;
    logic [2:0]  rts, rtr;
    logic [31:0] in_data;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // Only the selected channel is ever offered a slot; rtr stays low while in reset.
    assign rts     = {b_rts, g_rts, r_rts};
    assign rtr     = sel_q & {3{~full & rst_}};
    assign in_xfc  = |(rts & rtr);
    assign out_xfc = ~empty & out_rtr;

    always_comb begin
        in_data = r_data;
        if (sel_q[1]) in_data = g_data;
        if (sel_q[2]) in_data = b_data;
    end

    always_comb begin
        sel_d        = sel_q;
        wr_addr_d    = wr_addr_q;
        rd_addr_d    = rd_addr_q;
        count_d      = count_q;
        mem_ptr_d    = mem_ptr_q;
        queue_d      = queue_q;
        frame_done_d = 1'b0;
        if (en) begin
            // Restart discards any transfer handshaked in this same cycle.
            sel_d     = SEL_R;
            wr_addr_d = '0;
            rd_addr_d = '0;
            count_d   = '0;
            mem_ptr_d = '0;
        end else begin
            if (in_xfc) begin
                queue_d[wr_addr_q] = in_data;
                wr_addr_d          = wr_addr_q + AW'(1);
                sel_d              = {sel_q[1:0], sel_q[2]};
            end
            if (out_xfc) begin
                rd_addr_d    = rd_addr_q + AW'(1);
                mem_ptr_d    = (mem_ptr_q == LAST_ADDR) ? '0 : mem_ptr_q + 17'd1;
                frame_done_d = (mem_ptr_q == LAST_ADDR);
            end
            case ({in_xfc, out_xfc})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            sel_q        <= SEL_R;
            wr_addr_q    <= '0;
            rd_addr_q    <= '0;
            count_q      <= '0;
            mem_ptr_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            sel_q        <= sel_d;
            wr_addr_q    <= wr_addr_d;
            rd_addr_q    <= rd_addr_d;
            count_q      <= count_d;
            mem_ptr_q    <= mem_ptr_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Storage is not reset; the pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        queue_q <= queue_d;
    end

    assign r_rtr      = rtr[0];
    assign g_rtr      = rtr[1];
    assign b_rtr      = rtr[2];
    assign out_rts    = ~empty;
    assign out_data   = queue_q[rd_addr_q];
    assign mem_ptr    = mem_ptr_q;
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_data_store.sv
// Directed bench for data_store: a vector table for the basic rotation cases plus
// hand sequences for full, restart, address wrap and streaming.
module tb_data_store;
    localparam int NA = 1000;

    logic        clk = 1'b0;
    logic        rst_ = 1'b0;
    logic        en = 1'b0;
    logic [31:0] r_data = '0, g_data = '0, b_data = '0;
    logic        r_rts = 1'b0, g_rts = 1'b0, b_rts = 1'b0;
    logic        r_rtr, g_rtr, b_rtr;
    logic [31:0] out_data;
    logic        out_rts;
    logic        out_rtr = 1'b0;
    logic [16:0] mem_ptr;
    logic        frame_done;

    int n_cmp = 0;
    int n_err = 0;
    int ch = 0;
    int exp_ptr = 0;
    logic exp_fd = 1'b0;
    int fd_seen = 0;

    data_store #(.NUM_ADDRS(NA), .DEPTH(8)) dut (
        .clk(clk), .rst_(rst_), .en(en),
        .r_data(r_data), .r_rts(r_rts), .r_rtr(r_rtr),
        .g_data(g_data), .g_rts(g_rts), .g_rtr(g_rtr),
        .b_data(b_data), .b_rts(b_rts), .b_rtr(b_rtr),
        .out_data(out_data), .out_rts(out_rts), .out_rtr(out_rtr),
        .mem_ptr(mem_ptr), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic r, g, b, ordy;
        logic [2:0] ertr;
        logic eo;
        logic [31:0] ed;
        logic [16:0] ep;
    } vec_t;
    vec_t vt[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] rtr_vec();
        return {b_rtr, g_rtr, r_rtr};
    endfunction

    task automatic drive_ch(input int c, input logic v, input logic [31:0] w);
        case (c)
            0: begin r_rts = v; r_data = w; end
            1: begin g_rts = v; g_data = w; end
            default: begin b_rts = v; b_data = w; end
        endcase
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_ = 1'b0; en = 1'b0; out_rtr = 1'b0;
        r_rts = 1'b0; g_rts = 1'b0; b_rts = 1'b0;
        #1;
        chk("rst_rtr", 32'(rtr_vec()), 32'h0);
        chk("rst_out_rts", 32'(out_rts), 32'h0);
        chk("rst_mem_ptr", 32'(mem_ptr), 32'h0);
        chk("rst_frame_done", 32'(frame_done), 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_ = 1'b1;
        #1;
        chk("post_rst_rtr", 32'(rtr_vec()), 32'h1);
        ch = 0; exp_ptr = 0; exp_fd = 1'b0;
    endtask

    task automatic push(input logic [31:0] w);
        logic [2:0] rv;
        @(negedge clk);
        drive_ch(ch, 1'b1, w);
        #1;
        rv = rtr_vec();
        chk("push_rtr", 32'(rv[ch]), 32'h1);
        @(posedge clk);
        #1;
        drive_ch(ch, 1'b0, w);
        ch = (ch + 1) % 3;
    endtask

    // Streams n words with out_rtr held high; checks order, address and frame_done.
    task automatic stream(input int n, input logic [31:0] base);
        logic [2:0] rv;
        exp_fd = 1'b0;
        for (int i = 0; i <= n; i++) begin
            @(negedge clk);
            out_rtr = 1'b1;
            if (i < n) drive_ch(ch, 1'b1, base + 32'(i));
            #1;
            rv = rtr_vec();
            if (i < n) chk("stream_rtr", 32'(rv[ch]), 32'h1);
            if (i > 0) begin
                chk("stream_out_rts", 32'(out_rts), 32'h1);
                chk("stream_data", out_data, base + 32'(i - 1));
                chk("stream_ptr", 32'(mem_ptr), 32'(exp_ptr));
            end
            chk("stream_fd", 32'(frame_done), 32'(exp_fd));
            if (frame_done === 1'b1) fd_seen++;
            @(posedge clk);
            #1;
            if (i < n) begin
                drive_ch(ch, 1'b0, '0);
                ch = (ch + 1) % 3;
            end
            if (i > 0) begin
                exp_fd  = (exp_ptr == NA - 1);
                exp_ptr = (exp_ptr == NA - 1) ? 0 : exp_ptr + 1;
            end else begin
                exp_fd = 1'b0;
            end
        end
        @(negedge clk);
        #1;
        chk("stream_drained", 32'(out_rts), 32'h0);
        chk("stream_fd_end", 32'(frame_done), 32'(exp_fd));
        if (frame_done === 1'b1) fd_seen++;
        out_rtr = 1'b0;
    endtask

    initial begin
        // {r,g,b,out_rtr, expected rtr {b,g,r}, out_rts, out_data, mem_ptr}
        vt[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 3'b001, 1'b0, 32'h00, 17'd0};
        vt[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 3'b010, 1'b1, 32'h11, 17'd0};
        vt[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 3'b100, 1'b1, 32'h22, 17'd1};
        vt[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 3'b001, 1'b1, 32'h33, 17'd2};
        vt[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 3'b001, 1'b0, 32'h00, 17'd3};
        vt[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 3'b001, 1'b0, 32'h00, 17'd3};
        vt[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 3'b001, 1'b0, 32'h00, 17'd3};
        vt[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 3'b001, 1'b0, 32'h00, 17'd3};
        vt[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 1'b1, 32'h11, 17'd3};
        vt[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 3'b010, 1'b1, 32'h11, 17'd3};
        vt[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0, 32'h00, 17'd4};

        do_reset();
        r_data = 32'h11; g_data = 32'h22; b_data = 32'h33;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            r_rts = vt[i].r; g_rts = vt[i].g; b_rts = vt[i].b; out_rtr = vt[i].ordy;
            #1;
            chk($sformatf("vec%0d_rtr", i), 32'(rtr_vec()), 32'(vt[i].ertr));
            chk($sformatf("vec%0d_out_rts", i), 32'(out_rts), 32'(vt[i].eo));
            chk($sformatf("vec%0d_ptr", i), 32'(mem_ptr), 32'(vt[i].ep));
            if (vt[i].eo) chk($sformatf("vec%0d_data", i), out_data, vt[i].ed);
        end

        // Fill to full, then one drain frees exactly one slot a cycle later.
        do_reset();
        for (int i = 0; i < 8; i++) push(32'hA0 + 32'(i));
        @(negedge clk);
        b_rts = 1'b1; b_data = 32'hA8; out_rtr = 1'b1;
        #1;
        chk("full_rtr", 32'(rtr_vec()), 32'h0);
        chk("full_head", out_data, 32'hA0);
        @(negedge clk);
        out_rtr = 1'b0;
        #1;
        chk("after_drain_rtr", 32'(rtr_vec()), 32'h4);
        chk("after_drain_head", out_data, 32'hA1);
        @(posedge clk);
        #1;
        b_rts = 1'b0; ch = 0;
        @(negedge clk);
        out_rtr = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            #1;
            chk("drain_rts", 32'(out_rts), 32'h1);
            chk("drain_data", out_data, 32'hA0 + 32'(i));
            @(negedge clk);
        end
        #1;
        chk("drain_empty", 32'(out_rts), 32'h0);
        chk("drain_ptr", 32'(mem_ptr), 32'd9);
        out_rtr = 1'b0;

        // Mid-frame reset with words buffered.
        push(32'hB0);
        push(32'hB1);
        do_reset();
        chk("midrst_empty", 32'(out_rts), 32'h0);

        // Restart with 5 words buffered and G selected, transfers in the same cycle.
        for (int i = 0; i < 7; i++) push(32'hC0 + 32'(i));
        @(negedge clk);
        out_rtr = 1'b1;
        @(negedge clk);
        @(negedge clk);
        out_rtr = 1'b0;
        #1;
        chk("pre_en_ptr", 32'(mem_ptr), 32'd2);
        chk("pre_en_head", out_data, 32'hC2);
        chk("pre_en_sel", 32'(rtr_vec()), 32'h2);
        en = 1'b1; g_rts = 1'b1; g_data = 32'hDD; out_rtr = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0; out_rtr = 1'b0;
        @(negedge clk);
        #1;
        chk("en_out_rts", 32'(out_rts), 32'h0);
        chk("en_ptr", 32'(mem_ptr), 32'h0);
        chk("en_sel", 32'(rtr_vec()), 32'h1);
        chk("en_fd", 32'(frame_done), 32'h0);
        @(negedge clk);
        #1;
        chk("en_g_ignored", 32'(out_rts), 32'h0);
        r_rts = 1'b1; r_data = 32'hEE;
        @(posedge clk);
        #1;
        r_rts = 1'b0; g_rts = 1'b0;
        @(negedge clk);
        #1;
        chk("en_r_out_rts", 32'(out_rts), 32'h1);
        chk("en_r_data", out_data, 32'hEE);
        chk("en_r_sel", 32'(rtr_vec()), 32'h2);
        chk("en_r_ptr", 32'(mem_ptr), 32'h0);

        do_reset();
        stream(300, 32'h1000);

        do_reset();
        fd_seen = 0;
        stream(NA - 2, 32'h20000);
        chk("pre_wrap_ptr", 32'(mem_ptr), 32'(NA - 2));
        stream(3, 32'h30000);
        chk("fd_once", 32'(fd_seen), 32'd1);
        chk("wrap_ptr", 32'(mem_ptr), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, limit %0d ns", 2000000);
        $fatal(1);
    end
endmodule

// File: doc/data_store.md
# data_store

Write-back end of the pixel pipeline. Collects processed 32-bit words from the red, green and blue channel stages in strict R→G→B rotation and buffers them in an 8-entry FIFO. Drains them to frame memory over an rts/rtr handshake with a wrapping 17-bit write address. It is the counterpart of the fetch stage that reads frame memory and distributes words across the three channels.

## Interface
- NUM_ADDRS, 115200, frame memory depth in 32-bit words; write address wraps after NUM_ADDRS-1
- DEPTH, 8, FIFO entries (power of two, ≥2)
- clk  in  1  clock, all state on rising edge
- rst_  in  1  asynchronous, active-low reset
- en  in  1  synchronous restart; same effect as reset, sampled on clk
- r_data  in  32  red channel word
- r_rts  in  1  red word valid
- r_rtr  out  1  block accepts red word
- g_data  in  32  green channel word
- g_rts  in  1  green word valid
- g_rtr  out  1  block accepts green word
- b_data  in  32  blue channel word
- b_rts  in  1  blue word valid
- b_rtr  out  1  block accepts blue word
- out_data  out  32  word at FIFO head
- out_rts  out  1  FIFO not empty
- out_rtr  in  1  memory accepts word
- mem_ptr  out  17  memory write address of the head word
- frame_done  out  1  one-cycle pulse on the transfer that writes address NUM_ADDRS-1

## Operation
- Channel selection: one-hot state sel ∈ {001=R, 010=G, 100=B}; reset/restart value 001.
- x_rtr = sel[x] & !full & rst_; only the selected channel can transfer. Unselected x_rts is ignored and held off.
- x_xfc = x_rts & x_rtr: write x_data to queue[wr_addr], wr_addr+1 (mod DEPTH), advance sel R→G→B→R.
- out_rts = !empty; out_data = queue[rd_addr], combinational from the registered queue.
- out_xfc = out_rts & out_rtr: rd_addr+1 (mod DEPTH); mem_ptr ← (mem_ptr==NUM_ADDRS-1) ? 0 : mem_ptr+1.
- Occupancy counter count (0..DEPTH): +1 on input transfer only, -1 on output transfer only, unchanged when both occur; full = (count==DEPTH), empty = (count==0).
- frame_done = out_xfc & (mem_ptr==NUM_ADDRS-1), registered: high the cycle after that transfer for one cycle.
- Reset or en: rd_addr=wr_addr=count=0, mem_ptr=0, sel=001, frame_done=0. Queue contents are not cleared; any in-flight words are discarded.

## Timing
- Reset values: r_rtr=1 (once rst_ released), g_rtr=0, b_rtr=0, out_rts=0, mem_ptr=0, frame_done=0. out_data is don't-care while out_rts=0.
- While rst_=0 all x_rtr=0.
- Input-to-output latency: a word accepted at edge N is visible on out_data with out_rts=1 after edge N (1 cycle). No combinational path from x_rts to out_rts.
- No fall-through, no bypass. When full, no input transfer occurs even if out_xfc occurs in the same cycle; x_rtr rises the cycle after the drain.
- Simultaneous input and output transfer when 0<count<DEPTH: both occur and count is unchanged.
- Output throughput: 1 word/cycle while not empty and out_rtr=1. Input throughput: 1 word/cycle across channels (R,G,B on consecutive cycles).
- mem_ptr is 17 bits and never exceeds NUM_ADDRS-1. Wrap happens only on out_xfc.
- en asserted in the same cycle as transfers: restart wins and the transfers are dropped.
- rst_ asserted mid-frame: immediate clear as above; after release, output restarts at address 0 with sel=R.

## Test plan
- Reset, then R=0x11, G=0x22, B=0x33 with out_rtr=1 → out_data sequence 0x11, 0x22, 0x33 at mem_ptr 0, 1, 2; sel back to R; mem_ptr=3.
- Assert g_rts and b_rts with r_rts=0 → no transfer, g_rtr=b_rtr=0, count stays 0. Assert r_rts → R accepted, then g_rtr=1.
- out_rtr=0, feed 8 words → count=8, all x_rtr=0. Then out_rtr=1 for 1 cycle → count=7, selected x_rtr=1 the next cycle; 9th word appears in order.
- Preload mem_ptr to 115198 via 115198 transfers, then push 3 words → writes at 115198, 115199, 0; frame_done pulses exactly once, after the 115199 write.
- Continuous R/G/B streaming with out_rtr=1 → count never exceeds 1, one word written per cycle, no loss or reorder over 300 words.
- Pulse en with 5 words buffered and sel=G → out_rts=0, mem_ptr=0, sel=R next cycle; next input accepted only from the red channel.
